jt49_envelope: RTL and testbench
================================

JT49_ENVELOPE -- requirements
Module: jt49_envelope

Interface
REQ-001 SHALL have parameter: ENV_W, default 5, envelope level width (32 steps).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cen  input  1  clock enable; state advances only when high, except restart and reset.
REQ-005 SHALL have port: step  input  1  toggling envelope-period output of the upstream period divider.
REQ-006 SHALL have port: restart  input  1  one-clk pulse on any write of the shape register.
REQ-007 SHALL have port: ctrl  input  4  shape {CONT, ATT, ALT, HOLD}, bit 3 down to 0; sampled on restart.
REQ-008 SHALL have port: env  output  ENV_W  current envelope level, registered.
REQ-009 SHALL have port: held  output  1  high while the envelope is frozen.

Function
REQ-010 SHALL register step as step_q when cen=1; a step event is cen=1 && step=1 && step_q=0 (rising edge only).
REQ-011 SHALL keep state: cnt[ENV_W-1:0], inv, shape latch, FSM {RUN, HOLD}.
REQ-012 SHALL drive env = inv ? ~cnt : cnt in RUN; in HOLD, drive the latched hold level.
REQ-013 On restart: latch ctrl; set cnt=0; set inv=~ATT; set state=RUN; set step_q=step (no spurious edge); takes effect regardless of cen.
REQ-014 In RUN, on a step event with cnt<2^ENV_W-1: cnt increments by 1; env changes on the next clk (1-cycle latency).
REQ-015 In RUN, on a step event with cnt=2^ENV_W-1 (end of cycle), the transition SHALL depend on the latched shape: CONT=0 -> HOLD at level 0.
REQ-016 End of cycle, CONT=1 and HOLD=1 -> HOLD at level all-ones if (ATT^ALT)=1, else 0.
REQ-017 End of cycle, CONT=1, HOLD=0, ALT=1 -> cnt wraps to 0, inv toggles, stays RUN (triangle).
REQ-018 End of cycle, CONT=1, HOLD=0, ALT=0 -> cnt wraps to 0, inv unchanged, stays RUN (sawtooth).
REQ-019 In HOLD, step events SHALL be ignored; only restart leaves HOLD.
REQ-020 Restart in the same cycle as a step event: restart SHALL win and the step SHALL be discarded.
REQ-021 SHALL ignore ctrl changes without restart.
REQ-022 SHALL assert held iff state=HOLD, registered with env.
REQ-023 With cen=0, cnt, inv, state and step_q SHALL stay unchanged.

Reset
REQ-024 rst SHALL override all other inputs, including restart.
REQ-025 On rst: state=HOLD, env=0, held=1, cnt=0, inv=0, shape latch=0, step_q=0.
REQ-026 After reset, env SHALL remain 0 until the first restart.

Structure
REQ-027 SHALL place the ctrl bit-index constants (CONT=3, ATT=2, ALT=1, HOLD=0) and the FSM state type in the shared jt49_pkg package.
REQ-028 SHALL be a single module with no sub-module; the upstream jt49_div instance lives in the parent.

Verification
REQ-029 Reset, then toggle step with cen=1 and no restart -> env=0 and held=1 throughout.
REQ-030 ctrl=4'b0000 and restart, then 32 step rises -> env 31,30,...,0, then HOLD at 0; further steps leave env=0.
REQ-031 ctrl=4'b1110 (triangle) and restart, then 64 rises -> env 0..31, then 31..0, held=0.
REQ-032 ctrl=4'b1101 (attack, hold) -> env 0..31, then held=1 with env=31; ctrl=4'b1111 -> hold at 0 after 0..31.
REQ-033 restart pulsed in the same cycle as a step rise mid-cycle (cnt=10) -> cnt=0, no increment, env reflects new ATT next clk.
REQ-034 cen held low across step toggles -> env frozen; rst asserted mid-RUN -> env=0 and held=1 next clk.

Source files
------------

// File: rtl/jt49_pkg.sv
// jt49_pkg: shape-register bit positions and envelope FSM state type
package jt49_pkg;
    localparam int CONT = 3;
    localparam int ATT  = 2;
    localparam int ALT  = 1;
    localparam int HOLD = 0;
    typedef enum logic {ST_RUN, ST_HOLD} env_st_e;
endpackage

// File: rtl/jt49_envelope.sv
// jt49_envelope: AY-3-8910 style envelope generator driven by a toggling period step
module jt49_envelope
    import jt49_pkg::*;
#(
    parameter int ENV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             step,
    input  logic             restart,
    input  logic [3:0]       ctrl,
    output logic [ENV_W-1:0] env,
    output logic             held
);
    env_st_e          state_q, state_d;
    logic [ENV_W-1:0] cnt_q, cnt_d, env_q, env_d;
    logic [3:0]       shape_q, shape_d;
    logic             inv_q, inv_d, step_q, step_d, lvl_q, lvl_d, held_q, held_d;
    logic             step_ev, last;
    assign env  = env_q;
    assign held = held_q;
    // Next state: restart dominates a coincident step; output level derived from next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shape_d = shape_q;
        inv_d   = inv_q;
        lvl_d   = lvl_q;
        step_d  = cen ? step : step_q;
        step_ev = cen & step & ~step_q;
        last    = &cnt_q;
        if (restart) begin
            shape_d = ctrl;
            cnt_d   = '0;
            inv_d   = ~ctrl[ATT];
            state_d = ST_RUN;
            step_d  = step;
        end else if (state_q == ST_RUN && step_ev) begin
            if (!last) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!shape_q[CONT] || shape_q[HOLD]) begin
                state_d = ST_HOLD;
                lvl_d   = shape_q[CONT] & (shape_q[ATT] ^ shape_q[ALT]);
            end else begin
                cnt_d = '0;
                inv_d = inv_q ^ shape_q[ALT];
            end
        end
        env_d  = state_d == ST_HOLD ? {ENV_W{lvl_d}} : (inv_d ? ~cnt_d : cnt_d);
        held_d = state_d == ST_HOLD;
    end
    // State and registered outputs; reset freezes the envelope at level 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            shape_q <= '0;
            inv_q   <= 1'b0;
            lvl_q   <= 1'b0;
            step_q  <= 1'b0;
            env_q   <= '0;
            held_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shape_q <= shape_d;
            inv_q   <= inv_d;
            lvl_q   <= lvl_d;
            step_q  <= step_d;
            env_q   <= env_d;
            held_q  <= held_d;
        end
    end
endmodule

// File: tb/tb_jt49_envelope.sv
// tb_jt49_envelope: scoreboard bench for the envelope generator
module tb_jt49_envelope;
    logic       clk = 1'b0, rst = 1'b1, cen = 1'b1, step = 1'b0, restart = 1'b0;
    logic [3:0] ctrl = 4'b0000;
    logic [4:0] env;
    logic       held;
    int         n_tests = 0, n_fail = 0;
    logic [5:0] sb[$];
    string      tq[$];

    jt49_envelope #(.ENV_W(5)) dut (
        .clk(clk), .rst(rst), .cen(cen), .step(step),
        .restart(restart), .ctrl(ctrl), .env(env), .held(held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic rs, input int e, input logic h, input string tag);
        logic [5:0] x;
        string      t;
        step    = s;
        restart = rs;
        sb.push_back({e[4:0], h});
        tq.push_back(tag);
        @(posedge clk);
        #1;
        restart = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            x = sb.pop_front();
            t = tq.pop_front();
            chk({t, "_env"}, int'(env), int'(x[5:1]));
            chk({t, "_held"}, int'(held), int'(x[0]));
        end
    endtask

    task automatic rise(input int e, input logic h, input string tag);
        cyc(1'b1, 1'b0, e, h, tag);
        cyc(1'b0, 1'b0, e, h, tag);
    endtask

    task automatic restart_to(input logic [3:0] c, input int e, input string tag);
        ctrl = c;
        cyc(1'b0, 1'b1, e, 1'b0, tag);
    endtask

    initial begin
        cyc(1'b0, 1'b0, 0, 1'b1, "reset0");
        cyc(1'b1, 1'b1, 0, 1'b1, "reset_over_restart");
        rst = 1'b0;
        for (int k = 0; k < 4; k++) rise(0, 1'b1, "idle_after_reset");

        restart_to(4'b0000, 31, "decay_start");
        for (int k = 1; k <= 31; k++) rise(31 - k, 1'b0, "decay");
        rise(0, 1'b1, "decay_end");
        for (int k = 0; k < 3; k++) rise(0, 1'b1, "decay_hold");

        restart_to(4'b1110, 0, "tri_start");
        for (int k = 1; k <= 66; k++) rise((k % 64) < 32 ? k % 64 : 63 - (k % 64), 1'b0, "triangle");

        restart_to(4'b1101, 0, "att_hold_start");
        for (int k = 1; k <= 31; k++) rise(k, 1'b0, "att_hold_ramp");
        rise(31, 1'b1, "att_hold_end");
        rise(31, 1'b1, "att_hold_stay");

        restart_to(4'b1111, 0, "att_alt_hold_start");
        for (int k = 1; k <= 31; k++) rise(k, 1'b0, "att_alt_hold_ramp");
        rise(0, 1'b1, "att_alt_hold_end");
        rise(0, 1'b1, "att_alt_hold_stay");

        restart_to(4'b1110, 0, "mid_start");
        for (int k = 1; k <= 10; k++) rise(k, 1'b0, "mid_ramp");
        ctrl = 4'b0000;
        cyc(1'b1, 1'b1, 31, 1'b0, "restart_beats_step");
        cyc(1'b0, 1'b0, 31, 1'b0, "restart_no_spurious");
        rise(30, 1'b0, "after_restart");
        ctrl = 4'b1111;
        rise(29, 1'b0, "ctrl_ignored");

        cen = 1'b0;
        for (int k = 0; k < 3; k++) rise(29, 1'b0, "cen_low_frozen");
        cen = 1'b1;
        cyc(1'b0, 1'b0, 29, 1'b0, "cen_back");
        rise(28, 1'b0, "cen_resume");
        cen = 1'b0;
        restart_to(4'b1110, 0, "restart_cen_low");
        cen = 1'b1;
        rise(1, 1'b0, "after_cen_low_restart");
        rise(2, 1'b0, "run_before_rst");
        rst = 1'b1;
        cyc(1'b1, 1'b0, 0, 1'b1, "rst_mid_run");
        rst = 1'b0;
        for (int k = 0; k < 2; k++) rise(0, 1'b1, "idle_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
